deser_comma_align: RTL and testbench

- Parametrised serial-to-parallel deserializer with comma-based word alignment and lock/loss-of-sync tracking.
- Next generation of the lane receiver: a single bit-rate clock, configurable word width and comma pattern, bit-level alignment hunt, and loss-of-sync recovery.
- Sits at the receive end of each serial lane and feeds the byte-level demux/FIFO logic.

---
 rtl/deser_pkg.sv | 21 ++
 rtl/deser_shift_window.sv | 31 +++
 rtl/deser_comma_align.sv | 157 +++++++++++++++
 tb/tb_deser_comma_align.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types, constants and width helper for the lane deserializer
package deser_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } deser_state_t;

    localparam logic [7:0] COMMA_K28_5 = 8'hBC;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/deser_shift_window.sv
// rtl/deser_shift_window.sv - serial shift register and the combinational WIDTH-bit window
module deser_shift_window #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] window
);

    logic [WIDTH-1:0] sr;

    // The window already contains the bit on data_in, so it equals the next shift-reg value.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign window = {sr[WIDTH-2:0], data_in};
        end else begin : g_lsb_first
            assign window = {data_in, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr <= '0;
        end else begin
            sr <= window;
        end
    end

endmodule

// File: rtl/deser_comma_align.sv
// rtl/deser_comma_align.sv - deserializer with comma alignment hunt, lock and loss-of-sync tracking
module deser_comma_align
    import deser_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COMMA     = WIDTH'(COMMA_K28_5),
    parameter int               LOCK_CNT  = 4,
    parameter int               MAX_RUN   = 16,
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_stb,
    output logic             active,
    output logic             sync_err
);

    localparam int BIT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam int CC_W  = (clog2(LOCK_CNT + 1) < 1) ? 1 : clog2(LOCK_CNT + 1);
    localparam int RUN_W = (clog2(MAX_RUN + 1) < 1) ? 1 : clog2(MAX_RUN + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CC_W-1:0]  CC_LOCK  = CC_W'(LOCK_CNT);
    // With the run check disabled the run counter just parks at all-ones.
    localparam logic [RUN_W-1:0] RUN_SAT  = (MAX_RUN == 0) ? {RUN_W{1'b1}} : RUN_W'(MAX_RUN);

    deser_state_t     state, state_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [CC_W-1:0]  comma_cnt, comma_cnt_nxt, comma_inc;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt, run_inc;
    logic [WIDTH-1:0] data_out_nxt;
    logic             valid_nxt, stb_nxt, active_nxt, sync_err_nxt;

    logic [WIDTH-1:0] window;
    logic             boundary;
    logic             is_comma;

    deser_shift_window #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_window (
        .clk     (clk),
        .reset_L (reset_L),
        .data_in (data_in),
        .window  (window)
    );

    assign boundary  = (bit_cnt == BIT_LAST);
    assign is_comma  = (window == COMMA);
    assign comma_inc = (comma_cnt == CC_LOCK) ? comma_cnt : comma_cnt + CC_W'(1);
    assign run_inc   = (run_cnt == RUN_SAT) ? run_cnt : run_cnt + RUN_W'(1);

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = boundary ? '0 : bit_cnt + BIT_W'(1);
        comma_cnt_nxt = comma_cnt;
        run_cnt_nxt   = run_cnt;
        data_out_nxt  = data_out;
        valid_nxt     = valid_out;
        stb_nxt       = 1'b0;
        active_nxt    = active;
        sync_err_nxt  = 1'b0;

        case (state)
            HUNT: begin
                valid_nxt  = 1'b0;
                active_nxt = 1'b0;
                // A match here defines the word phase: next boundary is WIDTH bits on.
                if (is_comma) begin
                    bit_cnt_nxt   = '0;
                    comma_cnt_nxt = CC_W'(1);
                    if (LOCK_CNT == 1) begin
                        state_nxt   = LOCKED;
                        run_cnt_nxt = '0;
                        active_nxt  = 1'b1;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end

            COUNT: begin
                valid_nxt = 1'b0;
                if (boundary) begin
                    stb_nxt = 1'b1;
                    if (is_comma) begin
                        comma_cnt_nxt = comma_inc;
                        if (comma_inc == CC_LOCK) begin
                            state_nxt   = LOCKED;
                            run_cnt_nxt = '0;
                            active_nxt  = 1'b1;
                        end
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = HUNT;
                    end
                end
            end

            LOCKED: begin
                active_nxt = 1'b1;
                if (boundary) begin
                    stb_nxt      = 1'b1;
                    data_out_nxt = window;
                    if (is_comma) begin
                        run_cnt_nxt = '0;
                        valid_nxt   = 1'b0;
                    end else begin
                        run_cnt_nxt = run_inc;
                        valid_nxt   = 1'b1;
                        if ((MAX_RUN != 0) && (run_inc == RUN_SAT)) begin
                            sync_err_nxt  = 1'b1;
                            valid_nxt     = 1'b0;
                            active_nxt    = 1'b0;
                            comma_cnt_nxt = '0;
                            state_nxt     = HUNT;
                        end
                    end
                end
            end

            default: begin
                state_nxt  = HUNT;
                valid_nxt  = 1'b0;
                active_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            run_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            word_stb  <= 1'b0;
            active    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            run_cnt   <= run_cnt_nxt;
            data_out  <= data_out_nxt;
            valid_out <= valid_nxt;
            word_stb  <= stb_nxt;
            active    <= active_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_deser_comma_align.sv
// tb/tb_deser_comma_align.sv - directed self-checking bench for deser_comma_align
module tb_deser_comma_align;

    logic       clk;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       word_stb;
    logic       active;
    logic       sync_err;

    int n_cmp;
    int n_fail;
    int stb_seen;
    int serr_seen;

    deser_comma_align #(
        .WIDTH     (8),
        .COMMA     (8'hBC),
        .LOCK_CNT  (4),
        .MAX_RUN   (16),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .word_stb  (word_stb),
        .active    (active),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
        if (word_stb === 1'b1) stb_seen++;
        if (sync_err === 1'b1) serr_seen++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        stb_seen  = 0;
        serr_seen = 0;
        reset_L   = 1'b0;
        data_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_stb", word_stb, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_sync_err", sync_err, 1'b0);
        reset_L = 1'b1;

        // Basic lock: 5x BC, then two payload words
        send_word(8'hBC);
        check("t1_bc1_active", active, 1'b0);
        check("t1_bc1_stb", word_stb, 1'b0);
        stb_seen = 0;
        send_word(8'hBC);
        check("t1_bc2_stb", word_stb, 1'b1);
        send_word(8'hBC);
        check("t1_bc3_active", active, 1'b0);
        send_word(8'hBC);
        check("t1_bc4_active", active, 1'b1);
        check("t1_bc4_valid", valid_out, 1'b0);
        send_word(8'hBC);
        check("t1_bc5_data", data_out, 8'hBC);
        check("t1_bc5_valid", valid_out, 1'b0);
        send_word(8'h3A);
        check("t1_3a_data", data_out, 8'h3A);
        check("t1_3a_valid", valid_out, 1'b1);
        check("t1_3a_stb", word_stb, 1'b1);
        send_word(8'h5C);
        check("t1_5c_data", data_out, 8'h5C);
        check("t1_5c_valid", valid_out, 1'b1);
        check("t1_stb_count", stb_seen, 6);

        // Alignment at bit offset 3
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (3) send_word(8'hBC);
        check("t2_pre_active", active, 1'b0);
        send_word(8'hBC);
        check("t2_lock_active", active, 1'b1);
        send_word(8'hA5);
        check("t2_a5_data", data_out, 8'hA5);
        check("t2_a5_valid", valid_out, 1'b1);

        // Broken comma sequence returns to hunt
        do_reset();
        repeat (3) send_word(8'hBC);
        send_word(8'h11);
        check("t3_11_active", active, 1'b0);
        check("t3_11_stb", word_stb, 1'b1);
        check("t3_11_valid", valid_out, 1'b0);
        repeat (3) send_word(8'hBC);
        check("t3_bc3_active", active, 1'b0);
        send_word(8'hBC);
        check("t3_relock_active", active, 1'b1);

        // Loss of sync after 16 non-comma words
        serr_seen = 0;
        repeat (15) send_word(8'h01);
        check("t4_15_serr_count", serr_seen, 0);
        check("t4_15_valid", valid_out, 1'b1);
        check("t4_15_active", active, 1'b1);
        send_word(8'h01);
        check("t4_16_sync_err", sync_err, 1'b1);
        check("t4_16_active", active, 1'b0);
        check("t4_16_valid", valid_out, 1'b0);
        check("t4_16_data", data_out, 8'h01);
        send_word(8'hBC);
        check("t4_serr_once", serr_seen, 1);
        check("t4_serr_cleared", sync_err, 1'b0);
        repeat (3) send_word(8'hBC);
        check("t4_relock_active", active, 1'b1);

        // A comma mid-run clears the run counter
        serr_seen = 0;
        repeat (15) send_word(8'h01);
        send_word(8'hBC);
        check("t5_bc_valid", valid_out, 1'b0);
        check("t5_bc_data", data_out, 8'hBC);
        repeat (15) send_word(8'h01);
        check("t5_serr_count", serr_seen, 0);
        check("t5_active", active, 1'b1);
        check("t5_valid", valid_out, 1'b1);

        // Asynchronous reset mid-word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        check("t6_async_data", data_out, 8'h00);
        check("t6_async_valid", valid_out, 1'b0);
        check("t6_async_active", active, 1'b0);
        check("t6_async_stb", word_stb, 1'b0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        send_word(8'hBC);
        check("t6_hunt_active", active, 1'b0);
        check("t6_hunt_stb", word_stb, 1'b0);
        repeat (3) send_word(8'hBC);
        check("t6_relock_active", active, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
